// File: rtl/iq_rx_pkg.sv
`default_nettype none
// ============================================================================
// Module      : iq_rx_pkg
// Description : Shared types and constants for the RX IQ frame scheduler.
//               Frame layout, state encoding and the stored frame width.
//               The stored width depends on IQ_RX_RX2_STORE_EN: when it is
//               defined the full 96-bit frame is kept, otherwise only the
//               48-bit RX1 half is kept.
// Revision    : 1.0 - initial release
// ============================================================================
package iq_rx_pkg;

    localparam int IQ_SAMPLE_W = 24;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        RUN    = 2'd2
    } iq_rx_state_e;

    // Field order gives the packed layout {RX2_I, RX2_Q, RX1_I, RX1_Q}.
    typedef struct packed {
        logic signed [IQ_SAMPLE_W-1:0] rx2_i;
        logic signed [IQ_SAMPLE_W-1:0] rx2_q;
        logic signed [IQ_SAMPLE_W-1:0] rx1_i;
        logic signed [IQ_SAMPLE_W-1:0] rx1_q;
    } iq_frame_t;

    typedef struct packed {
        logic signed [IQ_SAMPLE_W-1:0] rx1_i;
        logic signed [IQ_SAMPLE_W-1:0] rx1_q;
    } iq_rx1_frame_t;

`ifdef IQ_RX_RX2_STORE_EN
    localparam int IQ_FRAME_W = $bits(iq_frame_t);
`else
    localparam int IQ_FRAME_W = $bits(iq_rx1_frame_t);
`endif

endpackage
`default_nettype wire

// File: rtl/iq_frame_fifo.sv
`default_nettype none
// ============================================================================
// Module      : iq_frame_fifo
// Description : Synchronous frame FIFO with synchronous flush.
//               Pointers are one bit wider than the address so full and
//               empty are told apart by the MSB. A write while full is
//               accepted only when a pop happens in the same cycle. Read
//               data is the head entry (combinational from the memory).
// Ports       : clk, rst (async, active-high), i_flush, i_wr_en, i_wr_data,
//               i_rd_en, o_rd_data, o_full, o_empty, o_level
// Revision    : 1.0 - initial release
// ============================================================================
module iq_frame_fifo #(
    parameter int DATA_W = 96,
    parameter int DEPTH  = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_flush,
    input  logic                     i_wr_en,
    input  logic [DATA_W-1:0]        i_wr_data,
    input  logic                     i_rd_en,
    output logic [DATA_W-1:0]        o_rd_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_level
);
    localparam int c_AW = $clog2(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [c_AW:0]     r_wr_ptr;
    logic [c_AW:0]     r_rd_ptr;
    logic              w_rd_ok;
    logic              w_wr_ok;

    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_full    = (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]) &&
                       (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]);
    assign o_level   = r_wr_ptr - r_rd_ptr;
    assign o_rd_data = r_mem[r_rd_ptr[c_AW-1:0]];

    // A simultaneous pop frees the slot the write needs.
    assign w_rd_ok = i_rd_en && !o_empty;
    assign w_wr_ok = i_wr_en && (!o_full || w_rd_ok);

    always_ff @(posedge clk) begin
        if (w_wr_ok && !i_flush) begin
            r_mem[r_wr_ptr[c_AW-1:0]] <= i_wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_wr_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_rd_ok) r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/iq_rx_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : iq_rx_scheduler
// Description : Buffers RX IQ frames between the DDC and the parallel-bus
//               interface. Discards SETTLE_SAMPLES frames after enable or an
//               rx2 change, stores frames in a FIFO and presents one frame
//               per IQ_RX_READ_REQ. Owns the sticky iq_overrun flag and the
//               one-cycle underrun pulse.
// Config      : IQ_RX_RX2_STORE_EN - when defined RX2 samples are stored and
//               presented; when undefined frames are RX1 only and OUT_RX2_*
//               is tied to 0 (rx2 still triggers flush/settle on change).
// Ports       : clk_in, reset_in (async, active-high), enable, rx2,
//               rx_valid, RX1_I/Q, RX2_I/Q, IQ_RX_READ_REQ, overrun_clr,
//               OUT_RX1_I/Q, OUT_RX2_I/Q, in_empty, iq_overrun, underrun,
//               fill_level
// Revision    : 1.0 - initial release
// ============================================================================
module iq_rx_scheduler
    import iq_rx_pkg::*;
#(
    parameter int DEPTH          = 16,
    parameter int SETTLE_SAMPLES = 8
) (
    input  logic                          clk_in,
    input  logic                          reset_in,
    input  logic                          enable,
    input  logic                          rx2,
    input  logic                          rx_valid,
    input  logic signed [IQ_SAMPLE_W-1:0] RX1_I,
    input  logic signed [IQ_SAMPLE_W-1:0] RX1_Q,
    input  logic signed [IQ_SAMPLE_W-1:0] RX2_I,
    input  logic signed [IQ_SAMPLE_W-1:0] RX2_Q,
    input  logic                          IQ_RX_READ_REQ,
    input  logic                          overrun_clr,
    output logic signed [IQ_SAMPLE_W-1:0] OUT_RX1_I,
    output logic signed [IQ_SAMPLE_W-1:0] OUT_RX1_Q,
    output logic signed [IQ_SAMPLE_W-1:0] OUT_RX2_I,
    output logic signed [IQ_SAMPLE_W-1:0] OUT_RX2_Q,
    output logic                          in_empty,
    output logic                          iq_overrun,
    output logic                          underrun,
    output logic [$clog2(DEPTH):0]        fill_level
);
    localparam logic [1:0] c_ST_IDLE   = IDLE;
    localparam logic [1:0] c_ST_SETTLE = SETTLE;
    localparam logic [1:0] c_ST_RUN    = RUN;
    localparam logic [7:0] c_SETTLE_LOAD = 8'(SETTLE_SAMPLES);
    // With no settle samples a (re)load goes straight to RUN.
    localparam logic [1:0] c_ST_LOAD   = (SETTLE_SAMPLES == 0) ? c_ST_RUN : c_ST_SETTLE;

    logic [1:0]            r_state;
    logic [7:0]            r_settle_cnt;
    logic                  r_rx2_d;
    logic                  w_rx2_chg;
    logic                  w_flush;
    logic                  w_wr;
    logic                  w_pop;
    logic                  w_drop;
    logic                  w_full;
    logic                  w_empty;
    logic [IQ_FRAME_W-1:0] w_wr_data;
    logic [IQ_FRAME_W-1:0] w_rd_data;

`ifdef IQ_RX_RX2_STORE_EN
    iq_frame_t w_wr_frame;
    iq_frame_t w_head;
    assign w_wr_frame = '{rx2_i: RX2_I, rx2_q: RX2_Q, rx1_i: RX1_I, rx1_q: RX1_Q};
`else
    iq_rx1_frame_t w_wr_frame;
    iq_rx1_frame_t w_head;
    logic          w_unused_rx2;
    assign w_wr_frame   = '{rx1_i: RX1_I, rx1_q: RX1_Q};
    assign w_unused_rx2 = ^{RX2_I, RX2_Q};
`endif
    assign w_wr_data = w_wr_frame;
    assign w_head    = w_rd_data;

    // rx2 edge only matters once the receive path has left IDLE.
    assign w_rx2_chg = (rx2 != r_rx2_d) && (r_state != c_ST_IDLE);
    assign w_flush   = !enable || w_rx2_chg;
    assign w_wr      = (r_state == c_ST_RUN) && rx_valid && !w_flush;
    assign w_pop     = IQ_RX_READ_REQ && !w_empty;
    assign w_drop    = w_wr && w_full && !w_pop;
    assign in_empty  = w_empty;

    iq_frame_fifo #(
        .DATA_W (IQ_FRAME_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk       (clk_in),
        .rst       (reset_in),
        .i_flush   (w_flush),
        .i_wr_en   (w_wr),
        .i_wr_data (w_wr_data),
        .i_rd_en   (w_pop),
        .o_rd_data (w_rd_data),
        .o_full    (w_full),
        .o_empty   (w_empty),
        .o_level   (fill_level)
    );

    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            r_state      <= c_ST_IDLE;
            r_settle_cnt <= '0;
            r_rx2_d      <= 1'b0;
        end else begin
            r_rx2_d <= rx2;
            if (!enable) begin
                r_state <= c_ST_IDLE;
            end else begin
                case (r_state)
                    c_ST_IDLE: begin
                        r_state      <= c_ST_LOAD;
                        r_settle_cnt <= c_SETTLE_LOAD;
                    end
                    c_ST_SETTLE: begin
                        if (w_rx2_chg) begin
                            r_state      <= c_ST_LOAD;
                            r_settle_cnt <= c_SETTLE_LOAD;
                        end else if (rx_valid) begin
                            // Last discarded frame: the next valid is stored.
                            if (r_settle_cnt <= 8'd1) begin
                                r_state <= c_ST_RUN;
                            end
                            r_settle_cnt <= r_settle_cnt - 8'd1;
                        end
                    end
                    c_ST_RUN: begin
                        if (w_rx2_chg) begin
                            r_state      <= c_ST_LOAD;
                            r_settle_cnt <= c_SETTLE_LOAD;
                        end
                    end
                    default: r_state <= c_ST_IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            OUT_RX1_I  <= '0;
            OUT_RX1_Q  <= '0;
            underrun   <= 1'b0;
            iq_overrun <= 1'b0;
        end else begin
            underrun <= IQ_RX_READ_REQ && w_empty;
            // A new drop wins over a clear in the same cycle.
            if (w_drop) begin
                iq_overrun <= 1'b1;
            end else if (overrun_clr) begin
                iq_overrun <= 1'b0;
            end
            if (w_pop) begin
                OUT_RX1_I <= w_head.rx1_i;
                OUT_RX1_Q <= w_head.rx1_q;
            end
        end
    end

`ifdef IQ_RX_RX2_STORE_EN
    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            OUT_RX2_I <= '0;
            OUT_RX2_Q <= '0;
        end else if (w_pop) begin
            OUT_RX2_I <= rx2 ? w_head.rx2_i : '0;
            OUT_RX2_Q <= rx2 ? w_head.rx2_q : '0;
        end
    end
`else
    assign OUT_RX2_I = '0;
    assign OUT_RX2_Q = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_iq_rx_scheduler.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_iq_rx_scheduler
// Description : Self-checking bench for iq_rx_scheduler (DEPTH 16, 8 settle
//               samples). Vector table for settle/pop/underrun, directed
//               sequences for overrun, full read/write, rx2 flush and async
//               reset, then random traffic against a queue model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_iq_rx_scheduler;
    localparam int DEPTH  = 16;
    localparam int SETTLE = 8;
    localparam int LW     = $clog2(DEPTH) + 1;
`ifdef IQ_RX_RX2_STORE_EN
    localparam bit C_RX2_BUILT = 1'b1;
`else
    localparam bit C_RX2_BUILT = 1'b0;
`endif

    logic clk_in = 1'b0;
    logic reset_in = 1'b1;
    logic enable = 1'b0, rx2 = 1'b0, rx_valid = 1'b0, req = 1'b0, clr = 1'b0;
    logic signed [23:0] rx1_i = '0, rx1_q = '0, rx2_i = '0, rx2_q = '0;
    logic signed [23:0] o1i, o1q, o2i, o2q;
    logic in_empty, iq_overrun, underrun;
    logic [LW-1:0] fill_level;

    int n_checks = 0;
    int n_errors = 0;

    iq_rx_scheduler #(.DEPTH(DEPTH), .SETTLE_SAMPLES(SETTLE)) dut (
        .clk_in(clk_in), .reset_in(reset_in), .enable(enable), .rx2(rx2),
        .rx_valid(rx_valid), .RX1_I(rx1_i), .RX1_Q(rx1_q), .RX2_I(rx2_i),
        .RX2_Q(rx2_q), .IQ_RX_READ_REQ(req), .overrun_clr(clr),
        .OUT_RX1_I(o1i), .OUT_RX1_Q(o1q), .OUT_RX2_I(o2i), .OUT_RX2_Q(o2q),
        .in_empty(in_empty), .iq_overrun(iq_overrun), .underrun(underrun),
        .fill_level(fill_level)
    );

    always #5 clk_in = ~clk_in;

    initial begin
        #1ms;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [23:0] act, input logic [23:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic write_frames(input int base, input int n);
        for (int k = 0; k < n; k++) begin
            rx_valid = 1'b1;
            rx1_i = 24'(base + k);
            rx1_q = 24'(base + k + 24'h1000);
            tick();
        end
        rx_valid = 1'b0;
    endtask

    task automatic pop_check(input string nm, input int base, input int n);
        for (int k = 0; k < n; k++) begin
            req = 1'b1;
            tick();
            chk(nm, o1i, 24'(base + k));
        end
        req = 1'b0;
    endtask

    typedef struct {
        logic       vld;
        logic       rq;
        int         i1;
        logic       e_empty;
        int         e_fill;
        int         e_out;
        logic       e_und;
    } vec_t;

    function automatic vec_t mk(input logic vld, input logic rq, input int i1,
                                input logic e_empty, input int e_fill,
                                input int e_out, input logic e_und);
        vec_t v;
        v.vld = vld; v.rq = rq; v.i1 = i1; v.e_empty = e_empty;
        v.e_fill = e_fill; v.e_out = e_out; v.e_und = e_und;
        return v;
    endfunction

    typedef struct packed {
        logic [23:0] i1, q1, i2, q2;
    } frm_t;

    vec_t        tbl [15];
    frm_t        m_q [$];
    frm_t        f, head;
    logic [23:0] m_o1i, m_o1q, m_o2i, m_o2q;
    bit          m_known, m_ovr, m_und, pop, room;

    initial begin
        // Settle discard, pops, then an underrun on the empty FIFO.
        tbl[0] = mk(0, 0, 0, 1, 0, 0, 0);
        for (int k = 1; k <= 10; k++)
            tbl[k] = mk(1, 0, k, (k <= SETTLE), (k <= SETTLE) ? 0 : k - SETTLE, 0, 0);
        tbl[11] = mk(0, 1, 0, 0, 1, 9, 0);
        tbl[12] = mk(0, 1, 0, 1, 0, 10, 0);
        tbl[13] = mk(0, 1, 0, 1, 0, 10, 1);
        tbl[14] = mk(0, 0, 0, 1, 0, 10, 0);

        // Reset values
        tick(); tick();
        chk("rst_empty", 24'(in_empty), 24'd1);
        chk("rst_fill", 24'(fill_level), 24'd0);
        chk("rst_ovr", 24'(iq_overrun), 24'd0);
        chk("rst_und", 24'(underrun), 24'd0);
        chk("rst_out", o1i | o1q | o2i | o2q, 24'd0);
        reset_in = 1'b0;

        enable = 1'b1;
        rx2_i = 24'h777; rx2_q = 24'h555;
        for (int r = 0; r < 15; r++) begin
            rx_valid = tbl[r].vld; req = tbl[r].rq; rx1_i = 24'(tbl[r].i1);
            tick();
            chk($sformatf("tbl%0d_empty", r), 24'(in_empty), 24'(tbl[r].e_empty));
            chk($sformatf("tbl%0d_fill", r), 24'(fill_level), 24'(tbl[r].e_fill));
            chk($sformatf("tbl%0d_out", r), o1i, 24'(tbl[r].e_out));
            chk($sformatf("tbl%0d_und", r), 24'(underrun), 24'(tbl[r].e_und));
            chk($sformatf("tbl%0d_rx2off", r), o2i, 24'd0);
        end
        rx_valid = 1'b0; req = 1'b0;

        // 17 writes into 16 slots: last frame lost, overrun set.
        write_frames(100, 17);
        chk("ovf_fill", 24'(fill_level), 24'd16);
        chk("ovf_flag", 24'(iq_overrun), 24'd1);
        clr = 1'b1; tick(); clr = 1'b0;
        chk("ovf_clr", 24'(iq_overrun), 24'd0);
        pop_check("ovf_pop", 100, 16);
        chk("ovf_drained", 24'(in_empty), 24'd1);

        // Full FIFO with simultaneous write and pop.
        write_frames(200, 16);
        rx_valid = 1'b1; rx1_i = 24'd216; req = 1'b1;
        tick();
        rx_valid = 1'b0; req = 1'b0;
        chk("fullrw_out", o1i, 24'd200);
        chk("fullrw_fill", 24'(fill_level), 24'd16);
        chk("fullrw_ovr", 24'(iq_overrun), 24'd0);
        // Drop and clear in the same cycle: set wins.
        rx_valid = 1'b1; rx1_i = 24'd999; clr = 1'b1;
        tick();
        rx_valid = 1'b0; clr = 1'b0;
        chk("setwins_ovr", 24'(iq_overrun), 24'd1);
        chk("setwins_fill", 24'(fill_level), 24'd16);
        pop_check("fullrw_pop", 201, 16);
        chk("fullrw_drained", 24'(fill_level), 24'd0);

        // Underrun hold after OUT_RX1_Q = 0x123456.
        rx_valid = 1'b1; rx1_i = 24'h42; rx1_q = 24'h123456; clr = 1'b1;
        tick();
        rx_valid = 1'b0; clr = 1'b0;
        chk("und_clr", 24'(iq_overrun), 24'd0);
        req = 1'b1; tick();
        chk("und_popq", o1q, 24'h123456);
        chk("und_none", 24'(underrun), 24'd0);
        tick(); req = 1'b0;
        chk("und_hold", o1q, 24'h123456);
        chk("und_pulse", 24'(underrun), 24'd1);
        tick();
        chk("und_end", 24'(underrun), 24'd0);
        chk("und_hold2", o1q, 24'h123456);

        // rx2 toggle flushes and re-enters SETTLE.
        write_frames(500, 5);
        chk("rx2_pre_fill", 24'(fill_level), 24'd5);
        rx2 = 1'b1; tick();
        chk("rx2_flush_fill", 24'(fill_level), 24'd0);
        chk("rx2_flush_empty", 24'(in_empty), 24'd1);
        for (int k = 0; k < SETTLE; k++) begin
            rx_valid = 1'b1; rx1_i = 24'(300 + k); rx2_i = 24'(24'h100 + k);
            tick();
        end
        chk("rx2_settle_fill", 24'(fill_level), 24'd0);
        rx1_i = 24'd308; rx2_i = 24'hABCDE; tick(); rx_valid = 1'b0;
        chk("rx2_run_fill", 24'(fill_level), 24'd1);
        req = 1'b1; tick(); req = 1'b0;
        chk("rx2_pop_rx1", o1i, 24'd308);
        chk("rx2_pop_rx2", o2i, C_RX2_BUILT ? 24'hABCDE : 24'd0);

        // Async reset mid-burst with 3 frames stored.
        write_frames(400, 3);
        req = 1'b1; tick(); req = 1'b0;
        chk("ar_pre_out", o1i, 24'd400);
        #2 reset_in = 1'b1;
        #1;
        chk("ar_out", o1i | o1q | o2i | o2q, 24'd0);
        chk("ar_empty", 24'(in_empty), 24'd1);
        chk("ar_fill", 24'(fill_level), 24'd0);
        tick(); reset_in = 1'b0;
        tick();  // IDLE -> SETTLE
        write_frames(600, SETTLE);
        chk("ar_settle_fill", 24'(fill_level), 24'd0);
        write_frames(700, 1);
        chk("ar_run_fill", 24'(fill_level), 24'd1);
        pop_check("ar_pop", 700, 1);

        // Random traffic against a queue model (enable=1, rx2=1, RUN, empty).
        m_known = 1'b0; m_ovr = 1'b0;
        m_o1i = '0; m_o1q = '0; m_o2i = '0; m_o2q = '0;
        for (int c = 0; c < 3000; c++) begin
            if (((c / 250) % 2) == 0) begin
                rx_valid = ($urandom_range(0, 9) < 8);
                req      = ($urandom_range(0, 9) < 2);
            end else begin
                rx_valid = ($urandom_range(0, 9) < 2);
                req      = ($urandom_range(0, 9) < 8);
            end
            clr = ($urandom_range(0, 19) == 0);
            f.i1 = 24'($urandom); f.q1 = 24'($urandom);
            f.i2 = 24'($urandom); f.q2 = 24'($urandom);
            rx1_i = f.i1; rx1_q = f.q1; rx2_i = f.i2; rx2_q = f.q2;

            pop   = req && (m_q.size() > 0);
            m_und = req && (m_q.size() == 0);
            room  = (m_q.size() < DEPTH) || pop;
            if (pop) begin
                head  = m_q.pop_front();
                m_o1i = head.i1; m_o1q = head.q1;
                m_o2i = C_RX2_BUILT ? head.i2 : 24'd0;
                m_o2q = C_RX2_BUILT ? head.q2 : 24'd0;
                m_known = 1'b1;
            end
            if (rx_valid && room) m_q.push_back(f);
            if (rx_valid && !room) m_ovr = 1'b1;
            else if (clr) m_ovr = 1'b0;

            tick();
            chk("rnd_fill", 24'(fill_level), 24'(m_q.size()));
            chk("rnd_empty", 24'(in_empty), 24'(m_q.size() == 0));
            chk("rnd_ovr", 24'(iq_overrun), 24'(m_ovr));
            chk("rnd_und", 24'(underrun), 24'(m_und));
            if (m_known) begin
                chk("rnd_o1i", o1i, m_o1i);
                chk("rnd_o1q", o1q, m_o1q);
                chk("rnd_o2i", o2i, m_o2i);
                chk("rnd_o2q", o2q, m_o2q);
            end
        end
        rx_valid = 1'b0; req = 1'b0; clr = 1'b0;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/iq_rx_scheduler.md
# iq_rx_scheduler

Buffers and sequences RX IQ frames between the DDC output stage and the STM32 parallel-bus interface. It captures RX1 (and optionally RX2) I/Q words on each DDC valid strobe and discards DDC settling samples after enable or mode change. Frames are held in a small FIFO and one frame is presented per bus read request. It drives the `in_empty` status consumed by the bus interface, and it owns the `iq_overrun` flag that the bus interface returns in SEND PARAMS bit 2.

## Interface
- `DEPTH`, 16 — FIFO depth in frames; power of two, 4..64.
- `SETTLE_SAMPLES`, 8 — DDC frames discarded after enable or `rx2` change; 0..255.
- `clk_in` input 1 — single clock; DDC and bus interface are synchronous to it.
- `reset_in` input 1 — asynchronous, active-high reset.
- `enable` input 1 — receive path active (the bus interface's `rx1`).
- `rx2` input 1 — RX2 channel included in frames.
- `rx_valid` input 1 — one-cycle strobe; RX inputs valid.
- `RX1_I`, `RX1_Q`, `RX2_I`, `RX2_Q` input 24 each (signed) — DDC samples.
- `IQ_RX_READ_REQ` input 1 — one-cycle pop request from the bus interface.
- `overrun_clr` input 1 — clears `iq_overrun`.
- `OUT_RX1_I`, `OUT_RX1_Q`, `OUT_RX2_I`, `OUT_RX2_Q` output 24 each (signed) — presented frame.
- `in_empty` output 1 — FIFO holds no frame.
- `iq_overrun` output 1 — sticky; a frame was dropped.
- `underrun` output 1 — one-cycle pulse; pop requested while empty.
- `fill_level` output $clog2(DEPTH)+1 — frames stored.

## Operation
- **Reset values.** All outputs are 0 except `in_empty`, which is 1. State is IDLE and the pointers are 0.
- **States and transitions.**
  - IDLE: the FIFO is held empty and `rx_valid` is ignored. `enable` = 1 moves to SETTLE and loads `settle_cnt` = `SETTLE_SAMPLES`.
  - SETTLE: each `rx_valid` decrements `settle_cnt` and the frame is discarded. At 0, or on entry with `SETTLE_SAMPLES` = 0, the block moves to RUN.
  - RUN: each `rx_valid` writes one frame {RX2_I, RX2_Q, RX1_I, RX1_Q} at `wr_ptr`.
  - From any state, `enable` = 0 goes to IDLE and flushes the FIFO.
  - In SETTLE or RUN, a change of `rx2` (registered edge detect) flushes the FIFO and re-enters SETTLE with a reloaded count.
- **Write when full.** The incoming frame is dropped (newest lost) and `iq_overrun` is set. If `IQ_RX_READ_REQ` is asserted in the same cycle, the pop frees a slot, the write succeeds, and no overrun is flagged.
- **Pop.** `IQ_RX_READ_REQ` with the FIFO non-empty registers the head frame onto the OUT_* ports and advances `rd_ptr`.
- **Pop when empty.** The OUT_* ports hold their previous value and `underrun` pulses for one cycle.
- **Read/write ordering.** A read and a write in the same cycle are both honoured and `fill_level` is unchanged. A write to an empty FIFO is not readable until the next cycle (no bypass).
- **Overrun flag.** `overrun_clr` and a new overrun in the same cycle leave `iq_overrun` = 1 (set wins).
- **Flush.** A flush zeroes the pointers and `fill_level` but does not clear `iq_overrun` or the OUT_* ports.
- **Pointers.** Pointers are $clog2(DEPTH)+1 bits wide. Full when the MSBs differ and the lower bits are equal; empty when the pointers are equal. Pointers wrap naturally.
- **`rx2` = 0.** RX2 fields are still stored. `OUT_RX2_*` is forced to 0 when `rx2` = 0 at pop time.

## Timing
- Pop latency is 1: `IQ_RX_READ_REQ` at cycle n gives OUT_* valid from n+1 until the next pop.
- `in_empty` and `fill_level` are registered and reflect a write at n from n+1.
- The bus interface issues at most one pop per 6 (RX1 only) or 12 (RX1+RX2) bus cycles; the block also supports back-to-back pops.
- Flush takes effect the cycle after `enable` falls or `rx2` toggles.
- Asynchronous reset mid-operation returns all outputs to their reset values immediately; behaviour resumes from IDLE on the first clock after `reset_in` falls.

## Configuration
- `IQ_RX_RX2_STORE_EN`
  - Defined: RX2 storage is built (96-bit frames) and the behaviour above applies.
  - Undefined: frames are 48 bits (RX1 only), `OUT_RX2_*` is tied to 0, and the `rx2` input still triggers flush/SETTLE on change.

## Structure
- Shared package `iq_rx_pkg`:
  - `iq_frame_t` struct: four signed [23:0] fields.
  - State enum {IDLE, SETTLE, RUN}.
  - Constant `IQ_SAMPLE_W` = 24.
- One sub-module, `iq_frame_fifo`: a parameterised synchronous FIFO (data width, depth, full/empty/level, synchronous flush).
- State machine, settle counter, overrun/underrun logic and output registers live in the top.

## Test plan
- Reset, then `enable` = 1, `SETTLE_SAMPLES` = 8, 10 valid frames RX1_I = 1..10 → first 8 discarded; pops return RX1_I = 9 then 10; `in_empty` = 1 after the second pop.
- RUN, 17 writes with no pops (DEPTH = 16) → `fill_level` = 16, `iq_overrun` = 1, 17th frame lost. `overrun_clr` → flag 0; pops return frames 1..16 in order.
- Full FIFO with `rx_valid` and `IQ_RX_READ_REQ` in the same cycle → no overrun, `fill_level` stays 16, new frame readable as the last entry.
- Pop on empty FIFO after OUT_RX1_Q = 0x123456 → OUT holds 0x123456; `underrun` high exactly 1 cycle.
- `rx2` toggled 0→1 with 5 frames stored → `fill_level` = 0 next cycle; state SETTLE; OUT_RX2_* nonzero only on frames stored after settle.
- `reset_in` pulsed mid-burst with 3 frames stored → OUT_* = 0, `in_empty` = 1 asynchronously; state IDLE after release.
